// File: rtl/pipeline_3_memory.sv
// pipeline_3_memory
// Memory-access stage of the pipelined datapath, directly after execute.
// It captures the execute-stage control word, ALU result, store data and
// destination register number, and issues at most one data-memory access
// per instruction over a req/ready handshake. Upstream is stalled while
// that access is outstanding. The write-back value is the ALU result, or
// the loaded word for a pure load.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   control_in[21:0]  control word from execute (all-zero = bubble)
//                     [11] mem_read, [12] mem_write, [13] reg_write
//   result_in[15:0]   ALU result: memory address / non-load write-back value
//   data_Rd_in[15:0]  forwarded Rd value, used as store data
//   num_Rd_in[2:0]    destination register number
//   mem_ready         memory completes the current request this cycle
//   mem_rdata[15:0]   read data, qualified by mem_ready during a read
//   stall_out         upstream must hold; this stage is not capturing
//   mem_req/mem_we/mem_addr/mem_wdata   request to data memory (0 when idle)
//   control_out, num_Rd_out            captured control word / Rd number
//   wb_data_out, wb_valid_out          write-back value and its qualifier
//   mem_err_out       sticky flag: an access was abandoned after TIMEOUT cycles
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | stage register open; holds the last captured instruction
// ST_REQ   | memory request outstanding; upstream stalled

module pipeline_3_memory #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] control_in,
  input  logic [15:0] result_in,
  input  logic [15:0] data_Rd_in,
  input  logic [2:0]  num_Rd_in,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [21:0] control_out,
  output logic [15:0] wb_data_out,
  output logic [2:0]  num_Rd_out,
  output logic        wb_valid_out,
  output logic        mem_err_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Counter value seen in the last permitted REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [21:0] ctrl_q;
  logic [15:0] res_q;
  logic [15:0] rd_data_q;
  logic [2:0]  num_q;
  logic [15:0] load_q, load_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic stage_en;
  logic in_mem_op;
  logic cap_read;
  logic cap_write;
  logic cap_is_load;

  assign stage_en    = (state_q == ST_IDLE);
  // A bubble has no memory bits set, so the non-bubble check is implied.
  assign in_mem_op   = control_in[11] | control_in[12];
  assign cap_read    = ctrl_q[11];
  assign cap_write   = ctrl_q[12];
  // Read and write together is treated as a write; the load path is unused.
  assign cap_is_load = cap_read & ~cap_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      res_q     <= '0;
      rd_data_q <= '0;
      num_q     <= '0;
    end else if (stage_en) begin
      ctrl_q    <= control_in;
      res_q     <= result_in;
      rd_data_q <= data_Rd_in;
      num_q     <= num_Rd_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_mem_op) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          if (cap_is_load) begin
            load_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          load_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stall depends on state only, never on mem_ready, to keep it off the
  // memory's combinational ready path.
  assign stall_out    = (state_q == ST_REQ);
  assign mem_req      = (state_q == ST_REQ);
  assign mem_we       = (state_q == ST_REQ) & cap_write;
  assign mem_addr     = (state_q == ST_REQ) ? res_q : 16'h0000;
  assign mem_wdata    = (state_q == ST_REQ) ? rd_data_q : 16'h0000;

  assign control_out  = ctrl_q;
  assign num_Rd_out   = num_q;
  assign wb_data_out  = cap_is_load ? load_q : res_q;
  assign wb_valid_out = (state_q == ST_IDLE) & (ctrl_q != 22'd0);
  assign mem_err_out  = err_q;

endmodule

// File: tb/tb_pipeline_3_memory.sv
module tb_pipeline_3_memory;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] control_in = '0;
  logic [15:0] result_in = '0;
  logic [15:0] data_Rd_in = '0;
  logic [2:0]  num_Rd_in = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        stall_out, mem_req, mem_we, wb_valid_out, mem_err_out;
  logic [15:0] mem_addr, mem_wdata, wb_data_out;
  logic [21:0] control_out;
  logic [2:0]  num_Rd_out;

  int n_vec = 0;
  int n_err = 0;

  pipeline_3_memory #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .control_in(control_in), .result_in(result_in),
    .data_Rd_in(data_Rd_in), .num_Rd_in(num_Rd_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .control_out(control_out), .wb_data_out(wb_data_out),
    .num_Rd_out(num_Rd_out), .wb_valid_out(wb_valid_out),
    .mem_err_out(mem_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction held by the stage and how many
  // request cycles it has spent so far.
  logic [21:0] m_ctrl = '0;
  logic [15:0] m_res = '0, m_rd = '0, m_load = '0;
  logic [2:0]  m_num = '0;
  bit          m_busy = 0, m_err = 0;
  int          m_waited = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl = '0; m_res = '0; m_rd = '0; m_num = '0; m_load = '0;
      m_busy = 0; m_err = 0; m_waited = 0;
    end else if (!m_busy) begin
      m_ctrl = control_in; m_res = result_in; m_rd = data_Rd_in; m_num = num_Rd_in;
      m_busy = (control_in != 0) && (control_in[11] || control_in[12]);
      m_waited = 0;
    end else begin
      m_waited++;
      if (mem_ready) begin
        m_busy = 0;
        if (m_ctrl[11] && !m_ctrl[12]) m_load = mem_rdata;
      end else if (m_waited == TIMEOUT) begin
        m_busy = 0; m_err = 1; m_load = '0;
      end
    end
  end

  always @(negedge clk) begin
    check("stall", stall_out, m_busy);
    check("mem_req", mem_req, m_busy);
    check("mem_we", mem_we, m_busy && m_ctrl[12]);
    check("mem_addr", mem_addr, m_busy ? m_res : 16'h0);
    check("mem_wdata", mem_wdata, m_busy ? m_rd : 16'h0);
    check("control_out", control_out, m_ctrl);
    check("num_Rd_out", num_Rd_out, m_num);
    check("wb_valid", wb_valid_out, !m_busy && (m_ctrl != 0));
    check("wb_data", wb_data_out, (m_ctrl[11] && !m_ctrl[12]) ? m_load : m_res);
    check("mem_err", mem_err_out, m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [21:0] c, input logic [15:0] r, input logic [15:0] d,
                       input logic [2:0] n);
    control_in = c; result_in = r; data_Rd_in = d; num_Rd_in = n;
  endtask

  // Serve the outstanding request: assert ready in the k-th request cycle
  // (k=0: never). Returns at the negedge of the first cycle without mem_req.
  task automatic do_mem(input int k, input logic [15:0] rdata, output int nreq,
                        output logic [15:0] a, output logic w, output logic [15:0] wd);
    bit done = 0;
    nreq = 0; a = '0; w = 0; wd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!mem_req) begin
        done = 1;
      end else begin
        nreq++;
        if (nreq == 1) begin a = mem_addr; w = mem_we; wd = mem_wdata; end
        if (nreq == k) begin mem_ready = 1; mem_rdata = rdata; end
        @(posedge clk);
        #1;
        mem_ready = 0; mem_rdata = '0;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL do_mem_bound: request still open after %0d cycles", nreq);
    end
  endtask

  int nreq;
  logic [15:0] fa, fwd;
  logic fw;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();

    // Non-memory ADD
    drive(22'h002001, 16'h1234, 16'h0000, 3'd5);
    tick();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("add_valid", wb_valid_out, 1);
    check("add_data", wb_data_out, 16'h1234);
    check("add_num", num_Rd_out, 5);
    check("add_stall", stall_out, 0);
    tick();

    // Load, ready in 3rd request cycle
    drive(22'h002800, 16'h0040, 16'h0000, 3'd1);
    tick();
    drive('0, '0, '0, '0);
    do_mem(3, 16'hBEEF, nreq, fa, fw, fwd);
    check("ld_reqcycles", nreq, 3);
    check("ld_addr", fa, 16'h0040);
    check("ld_we", fw, 0);
    check("ld_valid", wb_valid_out, 1);
    check("ld_data", wb_data_out, 16'hBEEF);
    tick();

    // Store, ready in 1st request cycle
    drive(22'h001000, 16'h0010, 16'h00AA, 3'd2);
    tick();
    drive('0, '0, '0, '0);
    do_mem(1, 16'h0000, nreq, fa, fw, fwd);
    check("st_reqcycles", nreq, 1);
    check("st_we", fw, 1);
    check("st_wdata", fwd, 16'h00AA);
    check("st_data", wb_data_out, 16'h0010);
    tick();

    // Load that times out
    drive(22'h002800, 16'h0050, 16'h0000, 3'd3);
    tick();
    drive('0, '0, '0, '0);
    do_mem(0, 16'h0000, nreq, fa, fw, fwd);
    check("to_reqcycles", nreq, TIMEOUT);
    check("to_err", mem_err_out, 1);
    check("to_valid", wb_valid_out, 1);
    check("to_data", wb_data_out, 16'h0000);
    tick();
    tick();
    check("to_err_sticky", mem_err_out, 1);

    // Spurious ready in IDLE, then load followed by held ADD
    mem_ready = 1; mem_rdata = 16'hDEAD;
    tick();
    tick();
    mem_ready = 0; mem_rdata = '0;
    drive(22'h002800, 16'h0080, 16'h0000, 3'd4);
    tick();
    drive(22'h002001, 16'h7777, 16'h0000, 3'd6);
    do_mem(2, 16'h1357, nreq, fa, fw, fwd);
    check("ord_reqcycles", nreq, 2);
    check("ord_ld_data", wb_data_out, 16'h1357);
    check("ord_ld_num", num_Rd_out, 4);
    tick();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("ord_add_data", wb_data_out, 16'h7777);
    check("ord_add_num", num_Rd_out, 6);
    tick();

    // Back-to-back: load then read+write (treated as write)
    drive(22'h002800, 16'h00C0, 16'h0000, 3'd7);
    tick();
    drive(22'h001800, 16'h0020, 16'hAAAA, 3'd0);
    do_mem(1, 16'h2468, nreq, fa, fw, fwd);
    check("b2b_ld_data", wb_data_out, 16'h2468);
    check("b2b_gap_req", mem_req, 0);
    tick();
    drive('0, '0, '0, '0);
    do_mem(1, 16'h9999, nreq, fa, fw, fwd);
    check("b2b_rw_reqcycles", nreq, 1);
    check("b2b_rw_we", fw, 1);
    check("b2b_rw_wdata", fwd, 16'hAAAA);
    check("b2b_rw_data", wb_data_out, 16'h0020);
    tick();

    // Reset pulsed mid-request
    drive(22'h002800, 16'h0100, 16'h0000, 3'd2);
    tick();
    drive('0, '0, '0, '0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall_out, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ctrl", control_out, 0);
    check("rst_valid", wb_valid_out, 0);
    check("rst_err", mem_err_out, 0);
    @(posedge clk);
    #1 rst = 0;
    drive(22'h002003, 16'h5555, 16'h0000, 3'd2);
    tick();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("post_rst_valid", wb_valid_out, 1);
    check("post_rst_data", wb_data_out, 16'h5555);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
